gpu_rect_walker: RTL
====================

Name: gpu_rect_walker

Overview:
Parametrised successor to the GPU rectangle stage (pipeline step 1). It accepts one rectangle command and emits one pixel descriptor per cycle, in row-major order: a sprite-sheet coordinate and a screen coordinate. Scaling uses a single unsigned fixed-point step per axis, which replaces the separate up/down-scale modes. The block supports mirroring, correct backpressure, zero-size commands and optional screen clipping. It feeds the address stage through a valid/ready interface.

Parameters:
COORD_W, 16, width of screen coordinates, width/height and integer part of step
FRAC_W, 8, fractional bits of step (step 1.0 = 1<<FRAC_W)
SS_W, 32, width of sprite-sheet coordinate outputs
SCREEN_W, 400, screen width in pixels (used only with clipping)
SCREEN_H, 240, screen height in pixels (used only with clipping)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset, asynchronous, active-high
re_valid  in  1  command valid
re_ready  out  1  command ready
re_ss_x, re_ss_y  in  COORD_W  sprite-sheet origin
re_screen_x, re_screen_y  in  COORD_W  screen origin
re_width, re_height  in  COORD_W  rectangle size in screen pixels
re_step_x, re_step_y  in  COORD_W+FRAC_W  unsigned fixed-point sprite-sheet step per screen pixel
re_mirror_x, re_mirror_y  in  1  mirror the screen placement
se_valid  out  1  pixel valid
se_ready  in  1  downstream ready
se_ss_x, se_ss_y  out  SS_W  sprite-sheet coordinate
se_screen_x, se_screen_y  out  COORD_W  screen coordinate
busy  out  1  command in progress

Behaviour:
- Reset values (async): state=IDLE, re_ready=0, se_valid=0, busy=0, all se_* payload outputs=0. re_ready rises on the first clock after rst deasserts.
- States:
  - IDLE: re_ready=1. On re_handshake, latch the command, clear counters x, y, acc_x, acc_y, set busy=1, and go to RUN. If width==0 or height==0, go to DONE instead.
  - RUN: generate pixels. After the handshake of pixel (width-1, height-1), go to DONE.
  - DONE: lasts one cycle; se_valid=0, busy=0, re_ready=1 on the next cycle, go to IDLE.
- Latency: command accepted at edge N; first pixel has se_valid=1 from edge N+1. Throughput is 1 pixel/cycle while se_ready=1.
- Output register: it advances only when se_valid=0 or se_ready=1. While se_valid && !se_ready, all payload is held stable.
- Pixel (x,y), with all fields registered:
  - se_ss_x = re_ss_x + (acc_x >> FRAC_W)
  - se_ss_y = re_ss_y + (acc_y >> FRAC_W)
  - se_screen_x = mirror_x ? screen_x+width-1-x : screen_x+x
  - se_screen_y is the same form using y and height.
- Accumulator arithmetic: acc_x/acc_y are 2*COORD_W+FRAC_W bits and never wrap. SS results are zero-extended and truncated to SS_W. Screen math is modulo 2^COORD_W.
- Counter advance per emitted pixel:
  - x+1 and acc_x += step_x.
  - At x==width-1: x=0, acc_x=0, y+1, acc_y += step_y.
- step=0 is legal: the same sprite-sheet texel is repeated.
- A command arriving while not in IDLE is not accepted, because re_ready=0.
- Reset mid-command aborts immediately; any pending output pixel is dropped.

Optional Feature:
GPU_RECT_CLIP_EN:
- Defined: a pixel with se_screen_x>=SCREEN_W or se_screen_y>=SCREEN_H (unsigned, after mirroring) is not presented. Counters still advance one position per cycle without waiting on se_ready. DONE is still reached after position (width-1, height-1), even if that position was clipped.
- Undefined: every pixel is emitted, and SCREEN_W/SCREEN_H are ignored.

Decomposition:
- gpu_pkg holds the state enum (IDLE, RUN, DONE) and a packed rect_cmd_t struct holding the command fields.
- One sub-module per axis: gpu_axis_stepper (counter, fixed-point accumulator, wrap detect, mirror), instantiated twice. The y instance advances on the x instance's wrap pulse.

Test Plan:
- Identity copy: ss(5,7), screen(10,20), 2x2, step 0x100, se_ready=1 → 4 pixels in consecutive cycles: ss (5,7),(6,7),(5,8),(6,8); screen (10,20),(11,20),(10,21),(11,21). busy falls and re_ready returns 2 cycles after the last handshake.
- Scaling: width 4, height 1, step_x=0x080 → ss_x 5,5,6,6. With step_x=0x200 → ss_x 5,7,9,11.
- Mirror and backpressure:
  - mirror_x=1, screen_x=10, width 3 → screen_x 12,11,10.
  - Toggle se_ready low on alternate cycles → payload held stable, no pixel lost or duplicated.
- Zero size: width=0, height=5 → no se_valid ever; re_ready=1 again 2 cycles after accept.
- Clipping (GPU_RECT_CLIP_EN): screen_x=398, width 4, height 1 → only screen_x 398,399 emitted; block returns to IDLE.
- Async reset: assert rst mid-row while se_valid=1 and se_ready=0 → se_valid=0 and busy=0 immediately. The next command after release starts from x=0, y=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the GPU rectangle walker: FSM state encoding and the
// latched rectangle command. Command fields are stored at a fixed maximum
// width so one struct serves every parameterisation of the walker; the walker
// zero-extends on capture and slices back to its own widths on use.
package gpu_pkg;

  localparam int GPU_MAX_COORD_W = 32;  // COORD_W must not exceed this
  localparam int GPU_MAX_STEP_W  = 48;  // COORD_W+FRAC_W must not exceed this

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [GPU_MAX_COORD_W-1:0] ss_x;
    logic [GPU_MAX_COORD_W-1:0] ss_y;
    logic [GPU_MAX_COORD_W-1:0] screen_x;
    logic [GPU_MAX_COORD_W-1:0] screen_y;
    logic [GPU_MAX_COORD_W-1:0] width;
    logic [GPU_MAX_COORD_W-1:0] height;
    logic [GPU_MAX_STEP_W-1:0]  step_x;
    logic [GPU_MAX_STEP_W-1:0]  step_y;
    logic                       mirror_x;
    logic                       mirror_y;
  } rect_cmd_t;

endpackage

// File: rtl/gpu_axis_stepper.sv
// One axis of the rectangle walk: position counter, fixed-point sprite-sheet
// accumulator, end-of-axis detect and mirrored screen coordinate.
// 'wrap' pulses on the advance that leaves the last position; the y-axis
// instance advances on the x-axis wrap.
module gpu_axis_stepper #(
  parameter int COORD_W = 16,
  parameter int FRAC_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [COORD_W-1:0]     size,
  input  logic [COORD_W-1:0]     origin,
  input  logic [COORD_W+FRAC_W-1:0] step,
  input  logic                   mirror,
  output logic                   last,
  output logic                   wrap,
  output logic [COORD_W-1:0]     screen,
  output logic [2*COORD_W-1:0]   ss_off
);

  // Wide enough that (size-1) * max step cannot overflow.
  localparam int ACC_W = 2*COORD_W + FRAC_W;

  logic [COORD_W-1:0] pos;
  logic [ACC_W-1:0]   acc;

  // Position and accumulator restart at each new command and at each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
      acc <= '0;
    end else if (clear) begin
      pos <= '0;
      acc <= '0;
    end else if (advance) begin
      if (last) begin
        pos <= '0;
        acc <= '0;
      end else begin
        pos <= pos + COORD_W'(1);
        acc <= acc + ACC_W'(step);
      end
    end
  end

  assign last   = (pos == size - COORD_W'(1));
  assign wrap   = advance && last;
  // Screen math is modulo 2^COORD_W; mirroring walks from the far edge back.
  assign screen = mirror ? (origin + size - COORD_W'(1) - pos) : (origin + pos);
  assign ss_off = acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/gpu_rect_walker.sv
// GPU rectangle walker: accepts one rectangle command and emits one pixel
// descriptor (sprite-sheet + screen coordinate) per cycle in row-major order.
// Optional screen clipping is enabled by defining GPU_RECT_CLIP_EN.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer holds valid and payload stable
// until that edge; ready may change freely and never depends on valid here.
module gpu_rect_walker
  import gpu_pkg::*;
#(
  parameter int COORD_W  = 16,
  parameter int FRAC_W   = 8,
  parameter int SS_W     = 32,
  parameter int SCREEN_W = 400,
  parameter int SCREEN_H = 240
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      re_valid,
  output logic                      re_ready,
  input  logic [COORD_W-1:0]        re_ss_x,
  input  logic [COORD_W-1:0]        re_ss_y,
  input  logic [COORD_W-1:0]        re_screen_x,
  input  logic [COORD_W-1:0]        re_screen_y,
  input  logic [COORD_W-1:0]        re_width,
  input  logic [COORD_W-1:0]        re_height,
  input  logic [COORD_W+FRAC_W-1:0] re_step_x,
  input  logic [COORD_W+FRAC_W-1:0] re_step_y,
  input  logic                      re_mirror_x,
  input  logic                      re_mirror_y,
  output logic                      se_valid,
  input  logic                      se_ready,
  output logic [SS_W-1:0]           se_ss_x,
  output logic [SS_W-1:0]           se_ss_y,
  output logic [COORD_W-1:0]        se_screen_x,
  output logic [COORD_W-1:0]        se_screen_y,
  output logic                      busy
);

  state_t    state, next_state;
  rect_cmd_t cmd;
  logic      gen_done;   // every position of the command has been visited

  logic accept, zero_size, can_load, pos_clip, advance, load, finish, last_pos;
  logic x_last, x_wrap, y_last, unused_y_wrap, unused_cmd;
  logic [COORD_W-1:0]   x_screen, y_screen;
  logic [2*COORD_W-1:0] x_ss_off, y_ss_off;

  assign accept    = (state == IDLE) && re_valid && re_ready;
  assign zero_size = (re_width == '0) || (re_height == '0);
  assign can_load  = !se_valid || se_ready;
  assign last_pos  = x_last && y_last;

`ifdef GPU_RECT_CLIP_EN
  // Off-screen positions are skipped without consuming an output slot.
  assign pos_clip = ({1'b0, x_screen} >= (COORD_W+1)'(SCREEN_W)) ||
                    ({1'b0, y_screen} >= (COORD_W+1)'(SCREEN_H));
`else
  localparam int unused_screen_dims = SCREEN_W + SCREEN_H;
  assign pos_clip = 1'b0;
`endif

  assign advance = (state == RUN) && !gen_done && (pos_clip || can_load);
  assign load    = advance && !pos_clip;
  // Last position visited and its pixel (if any) has left the output register.
  assign finish  = (state == RUN) && gen_done && can_load;
  assign unused_cmd = ^cmd;

  gpu_axis_stepper #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_x (
    .clk(clk), .rst(rst), .clear(accept), .advance(advance),
    .size(cmd.width[COORD_W-1:0]), .origin(cmd.screen_x[COORD_W-1:0]),
    .step(cmd.step_x[COORD_W+FRAC_W-1:0]), .mirror(cmd.mirror_x),
    .last(x_last), .wrap(x_wrap), .screen(x_screen), .ss_off(x_ss_off)
  );

  gpu_axis_stepper #(.COORD_W(COORD_W), .FRAC_W(FRAC_W)) u_y (
    .clk(clk), .rst(rst), .clear(accept), .advance(x_wrap),
    .size(cmd.height[COORD_W-1:0]), .origin(cmd.screen_y[COORD_W-1:0]),
    .step(cmd.step_y[COORD_W+FRAC_W-1:0]), .mirror(cmd.mirror_y),
    .last(y_last), .wrap(unused_y_wrap), .screen(y_screen), .ss_off(y_ss_off)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state: zero-size commands skip straight to DONE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = zero_size ? DONE : RUN;
      RUN:     if (finish) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Command capture, handshake flags and the pixel output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_ready    <= 1'b0;
      busy        <= 1'b0;
      se_valid    <= 1'b0;
      se_ss_x     <= '0;
      se_ss_y     <= '0;
      se_screen_x <= '0;
      se_screen_y <= '0;
      cmd         <= '0;
      gen_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            re_ready <= 1'b0;
            busy     <= 1'b1;
            gen_done <= 1'b0;
            cmd      <= '{ss_x:     GPU_MAX_COORD_W'(re_ss_x),
                          ss_y:     GPU_MAX_COORD_W'(re_ss_y),
                          screen_x: GPU_MAX_COORD_W'(re_screen_x),
                          screen_y: GPU_MAX_COORD_W'(re_screen_y),
                          width:    GPU_MAX_COORD_W'(re_width),
                          height:   GPU_MAX_COORD_W'(re_height),
                          step_x:   GPU_MAX_STEP_W'(re_step_x),
                          step_y:   GPU_MAX_STEP_W'(re_step_y),
                          mirror_x: re_mirror_x,
                          mirror_y: re_mirror_y};
          end else begin
            re_ready <= 1'b1;
          end
        end
        RUN: begin
          if (load) begin
            se_valid    <= 1'b1;
            se_ss_x     <= SS_W'(cmd.ss_x[COORD_W-1:0]) + SS_W'(x_ss_off);
            se_ss_y     <= SS_W'(cmd.ss_y[COORD_W-1:0]) + SS_W'(y_ss_off);
            se_screen_x <= x_screen;
            se_screen_y <= y_screen;
          end else if (se_ready) begin
            se_valid <= 1'b0;
          end
          if (advance && last_pos) gen_done <= 1'b1;
        end
        DONE: begin
          re_ready <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
